uart_reg_bridge: RTL
====================

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000; the maximum number of idle clocks allowed between bytes of one frame.
REQ-002 Parameter ACK_BYTE, default 8'h4B; the byte returned after a completed write.
REQ-003 i_clk  input  1  system clock.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_rx_data  input  8  received UART byte.
REQ-006 i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-007 o_tx_data  output  8  byte to transmit.
REQ-008 o_tx_valid  output  1  transmit request, held until accepted.
REQ-009 i_tx_ready  input  1  transmitter accepts o_tx_data on a rising edge where o_tx_valid and i_tx_ready are both high.
REQ-010 o_addr  output  16  register-map address.
REQ-011 o_wdata  output  16  register-map write data.
REQ-012 o_wen  output  1  register-map write strobe, one cycle.
REQ-013 i_q  input  16  register-map read data; registered by the map one clock after o_addr is stable with o_wen low.
REQ-014 o_err  output  1  one-cycle pulse on a protocol error.

Function
REQ-015 Frame formats shall be: write = 8'h57 ('W'), AH, AL, DH, DL; read = 8'h52 ('R'), AH, AL. All multi-byte fields are big-endian.
REQ-016 FSM states shall be IDLE, CMD_AH, CMD_AL, CMD_DH, CMD_DL, WR, RD_SET, RD_WAIT, RD_CAP, TX_HI, TX_LO and TX_ACK.
REQ-017 IDLE handling of a received byte:
  - 'W' or 'R' -> CMD_AH; the command is latched.
  - Any other byte -> o_err pulses the next cycle; the FSM stays in IDLE.
REQ-018 Address and data capture:
  - CMD_AH latches o_addr[15:8].
  - CMD_AL latches o_addr[7:0], then goes to CMD_DH for a write or RD_SET for a read.
  - CMD_DH latches o_wdata[15:8].
  - CMD_DL latches o_wdata[7:0], then goes to WR.
REQ-019 WR shall assert o_wen for exactly one cycle with o_addr and o_wdata stable, then go to TX_ACK; latency from the DL strobe to o_wen high is 1 clock.
REQ-020 Read sequence:
  - RD_SET holds o_addr with o_wen low.
  - RD_WAIT waits one cycle.
  - RD_CAP latches i_q into an internal 16-bit register, then goes to TX_HI.
REQ-021 Transmit states:
  - TX_HI sends the captured data [15:8]; TX_LO sends [7:0].
  - TX_ACK sends ACK_BYTE.
  - Each state holds o_tx_valid high with o_tx_data stable until the handshake completes, then advances (TX_HI -> TX_LO; TX_LO and TX_ACK -> IDLE).
REQ-022 o_tx_valid shall be low in every non-TX state.
REQ-023 Any i_rx_valid strobe in WR, RD_*, or TX_* states shall be discarded with no error.
REQ-024 Inter-byte timeout:
  - A counter clears on each accepted byte and counts while in CMD_AH..CMD_DL.
  - On reaching TIMEOUT_CYC-1 the FSM returns to IDLE, o_err pulses, and o_wen stays low.
  - The counter width is the ceiling of log2(TIMEOUT_CYC) bits and it never wraps.
REQ-025 o_addr and o_wdata shall retain their last values in IDLE.
REQ-026 o_err and o_wen shall never both be high in the same cycle.

Reset
REQ-027 On reset, the FSM shall go to IDLE and o_addr, o_wdata, o_tx_data, and the capture register shall be 0.
REQ-028 On reset, o_wen, o_tx_valid, o_err, and the timeout counter shall be 0.
REQ-029 Reset asserted mid-frame or mid-transmit shall abort immediately; no write and no further TX byte shall follow release.

Structure
REQ-030 A shared package shall hold the command codes 8'h57 and 8'h52, the ACK_BYTE default, and the FSM state encoding.
REQ-031 The design shall be a single module with no sub-modules; the timeout counter shall be inline.

Verification
REQ-032 Write test:
  - Stimulus: bytes 57 00 02 12 34.
  - Response: one o_wen pulse with o_addr=0002 and o_wdata=1234, then TX byte 4B.
REQ-033 Read test:
  - Stimulus: bytes 52 00 02 with i_q=ABCD.
  - Response: i_q captured in RD_CAP; TX bytes AB then CD, in order.
REQ-034 Back-pressure test:
  - Stimulus: i_tx_ready held low for 20 cycles during TX_HI.
  - Response: o_tx_valid stays high and o_tx_data stays AB throughout; CD is sent only after acceptance.
REQ-035 Error test:
  - Stimulus 1: byte 41 in IDLE. Response: one o_err pulse; state stays IDLE.
  - Stimulus 2: 57 00 then TIMEOUT_CYC idle cycles. Response: o_err pulses, no o_wen.
REQ-036 Reset test:
  - Stimulus: reset asserted after 57 00 02 12.
  - Response: all outputs return to 0; after release, DL byte 34 alone produces o_err and no write.

Source files
------------

// File: rtl/uart_reg_bridge_pkg.sv
// Shared constants for the UART-to-register-map bridge: command codes,
// default acknowledge byte and the FSM state encoding.
package uart_reg_bridge_pkg;

    localparam logic [7:0] CMD_WRITE        = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ         = 8'h52;  // 'R'
    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h4B;  // 'K'

    localparam int STATE_W = 4;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CMD_AH  = 4'd1;
    localparam logic [3:0] ST_CMD_AL  = 4'd2;
    localparam logic [3:0] ST_CMD_DH  = 4'd3;
    localparam logic [3:0] ST_CMD_DL  = 4'd4;
    localparam logic [3:0] ST_WR      = 4'd5;
    localparam logic [3:0] ST_RD_SET  = 4'd6;
    localparam logic [3:0] ST_RD_WAIT = 4'd7;
    localparam logic [3:0] ST_RD_CAP  = 4'd8;
    localparam logic [3:0] ST_TX_HI   = 4'd9;
    localparam logic [3:0] ST_TX_LO   = 4'd10;
    localparam logic [3:0] ST_TX_ACK  = 4'd11;

    function automatic logic is_cmd_byte(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// Byte-framed UART command decoder: 'W' AH AL DH DL writes the register map
// and answers ACK_BYTE; 'R' AH AL reads it and answers with two data bytes.
module uart_reg_bridge
    import uart_reg_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [15:0] o_addr,
    output logic [15:0] o_wdata,
    output logic        o_wen,
    input  logic [15:0] i_q,
    output logic        o_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic               is_read_q, is_read_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        cap_q, cap_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               wen_q, wen_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic in_frame;
    logic tx_done;

    assign in_frame = (state_q >= ST_CMD_AH) && (state_q <= ST_CMD_DL);
    assign tx_done  = tx_valid_q && i_tx_ready;

    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_d      = cap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        wen_d      = 1'b0;
        err_d      = 1'b0;
        cnt_d      = '0;

        // Inter-byte watchdog; an arriving byte always wins over expiry.
        if (in_frame && !i_rx_valid) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (is_cmd_byte(i_rx_data)) begin
                        state_d   = ST_CMD_AH;
                        is_read_d = (i_rx_data == CMD_READ);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CMD_AH: begin
                if (i_rx_valid) begin
                    addr_d[15:8] = i_rx_data;
                    state_d      = ST_CMD_AL;
                end
            end
            ST_CMD_AL: begin
                if (i_rx_valid) begin
                    addr_d[7:0] = i_rx_data;
                    state_d     = is_read_q ? ST_RD_SET : ST_CMD_DH;
                end
            end
            ST_CMD_DH: begin
                if (i_rx_valid) begin
                    wdata_d[15:8] = i_rx_data;
                    state_d       = ST_CMD_DL;
                end
            end
            ST_CMD_DL: begin
                if (i_rx_valid) begin
                    wdata_d[7:0] = i_rx_data;
                    wen_d        = 1'b1;
                    state_d      = ST_WR;
                end
            end
            ST_WR: begin
                tx_data_d  = ACK_BYTE;
                tx_valid_d = 1'b1;
                state_d    = ST_TX_ACK;
            end
            ST_RD_SET:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                // High byte is presented straight from i_q while cap_q loads.
                cap_d      = i_q;
                tx_data_d  = i_q[15:8];
                tx_valid_d = 1'b1;
                state_d    = ST_TX_HI;
            end
            ST_TX_HI: begin
                if (tx_done) begin
                    tx_data_d = cap_q[7:0];
                    state_d   = ST_TX_LO;
                end
            end
            ST_TX_LO, ST_TX_ACK: begin
                if (tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_q      <= cap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_addr     = addr_q;
    assign o_wdata    = wdata_q;
    assign o_wen      = wen_q;
    assign o_err      = err_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;

endmodule
